// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch run-control stage: state encoding,
// per-digit wrap limits and the default tick divider for a 100 MHz clock.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [3:0] DIG_MAX_DEC      = 4'd9;
    localparam logic [3:0] DIG_MAX_SEC_TENS = 4'd5;

    localparam int TICK_DIV_DEFAULT = 1_000_000;

endpackage

// File: rtl/stopwatch_timer_bcd_digit.sv
// One BCD counter digit with a programmable wrap value; four of these are
// chained through carry to form the SS.hh display count.
module bcd_digit (
    input  logic       clk,
    input  logic       clr,
    input  logic       en,
    input  logic       clear,
    input  logic [3:0] max,
    output logic [3:0] q,
    output logic       carry
);

    assign carry = en && (q == max);

    // A synchronous clear takes priority over counting so that zeroing never
    // races with a carry arriving from the digit below.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q <= 4'd0;
        end else if (clear) begin
            q <= 4'd0;
        end else if (en) begin
            q <= (q == max) ? 4'd0 : q + 4'd1;
        end
    end

endmodule

// File: rtl/stopwatch_timer.sv
// Stopwatch run control: prescales clk into 0.01 s ticks, drives a BCD
// SS.hh count and issues a one-cycle lap strobe aligned with the digits.
module stopwatch_timer
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       start_stop,
    input  logic       zero,
    input  logic       lap,
    output logic [3:0] dout0,
    output logic [3:0] dout1,
    output logic [3:0] dout2,
    output logic [3:0] dout3,
    output logic       lap_strobe,
    output logic       running,
    output logic       ovf
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    state_t        state;
    logic [PW-1:0] presc;
    logic          tick;
    logic          zero_clear;
    logic          start_clear;
    logic          carry0;
    logic          carry1;
    logic          carry2;
    logic          carry3;

    assign tick        = (state == RUN) && (presc == PRESC_LAST);
    assign zero_clear  = (state == PAUSE) && zero && !start_stop;
    assign start_clear = (state == IDLE) && start_stop;

    // Run/pause FSM; running is registered alongside the state it mirrors.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state   <= IDLE;
            running <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_stop) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (start_stop) begin
                        state   <= PAUSE;
                        running <= 1'b0;
                    end
                end
                PAUSE: begin
                    if (start_stop) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end else if (zero) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

    // The prescaler holds its value while paused so a resume loses no time.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            presc <= '0;
        end else if (start_clear || zero_clear) begin
            presc <= '0;
        end else if (state == RUN) begin
            presc <= tick ? '0 : presc + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            lap_strobe <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            lap_strobe <= (state == RUN) && lap;
            if (zero_clear) begin
                ovf <= 1'b0;
            end else if (carry3) begin
                ovf <= 1'b1;
            end
        end
    end

    bcd_digit u_dig0 (
        .clk   (clk),
        .clr   (clr),
        .en    (tick),
        .clear (zero_clear),
        .max   (DIG_MAX_DEC),
        .q     (dout0),
        .carry (carry0)
    );

    bcd_digit u_dig1 (
        .clk   (clk),
        .clr   (clr),
        .en    (carry0),
        .clear (zero_clear),
        .max   (DIG_MAX_DEC),
        .q     (dout1),
        .carry (carry1)
    );

    bcd_digit u_dig2 (
        .clk   (clk),
        .clr   (clr),
        .en    (carry1),
        .clear (zero_clear),
        .max   (DIG_MAX_DEC),
        .q     (dout2),
        .carry (carry2)
    );

    bcd_digit u_dig3 (
        .clk   (clk),
        .clr   (clr),
        .en    (carry2),
        .clear (zero_clear),
        .max   (DIG_MAX_SEC_TENS),
        .q     (dout3),
        .carry (carry3)
    );

endmodule

// File: tb/tb_stopwatch_timer.sv
// Directed bench for stopwatch_timer with TICK_DIV = 4: expectations are queued
// as each step is driven and popped against the DUT outputs afterwards.
module tb_stopwatch_timer;

    localparam int TICK_DIV = 4;

    logic       clk = 1'b0;
    logic       clr;
    logic       start_stop;
    logic       zero;
    logic       lap;
    logic [3:0] dout0;
    logic [3:0] dout1;
    logic [3:0] dout2;
    logic [3:0] dout3;
    logic       lap_strobe;
    logic       running;
    logic       ovf;

    typedef struct {
        string       tag;
        logic [18:0] value;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    stopwatch_timer #(.TICK_DIV(TICK_DIV)) dut (
        .clk        (clk),
        .clr        (clr),
        .start_stop (start_stop),
        .zero       (zero),
        .lap        (lap),
        .dout0      (dout0),
        .dout1      (dout1),
        .dout2      (dout2),
        .dout3      (dout3),
        .lap_strobe (lap_strobe),
        .running    (running),
        .ovf        (ovf)
    );

    // Expected value packs {dout3..dout0, running, lap_strobe, ovf}.
    task automatic pushExpect(input string tag, input logic [15:0] d,
                              input logic r, input logic s, input logic o);
        exp_t e;
        e.tag   = tag;
        e.value = {d, r, s, o};
        sbq.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t        e;
        logic [18:0] obs;
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_empty observed=none expected=entry");
        end else begin
            e   = sbq.pop_front();
            obs = {dout3, dout2, dout1, dout0, running, lap_strobe, ovf};
            assert (obs === e.value) else begin
                errors++;
                $error("[TB] FAIL %s observed dout=%h run=%b strobe=%b ovf=%b expected dout=%h run=%b strobe=%b ovf=%b",
                       e.tag, obs[18:3], obs[2], obs[1], obs[0],
                       e.value[18:3], e.value[2], e.value[1], e.value[0]);
            end
        end
    endtask

    // Called at a falling edge: drives pulses across exactly one rising edge.
    task automatic applyStimulus(input logic ss, input logic z, input logic l,
                                 input string tag, input logic [15:0] d,
                                 input logic r, input logic s, input logic o);
        pushExpect(tag, d, r, s, o);
        start_stop = ss;
        zero       = z;
        lap        = l;
        @(negedge clk);
        start_stop = 1'b0;
        zero       = 1'b0;
        lap        = 1'b0;
        checkOutput();
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitAndCheck(input int n, input string tag, input logic [15:0] d,
                                input logic r, input logic s, input logic o);
        pushExpect(tag, d, r, s, o);
        waitCycles(n);
        checkOutput();
    endtask

    initial begin
        clr        = 1'b1;
        start_stop = 1'b0;
        zero       = 1'b0;
        lap        = 1'b0;

        // Reset state
        @(negedge clk);
        pushExpect("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
        checkOutput();
        clr = 1'b0;
        waitAndCheck(2, "idle_after_reset", 16'h0000, 1'b0, 1'b0, 1'b0);

        // Start, first tick latency, pause/resume continuity
        applyStimulus(1, 0, 0, "start", 16'h0000, 1'b1, 1'b0, 1'b0);
        waitAndCheck(3, "pre_first_tick", 16'h0000, 1'b1, 1'b0, 1'b0);
        waitAndCheck(1, "first_tick", 16'h0001, 1'b1, 1'b0, 1'b0);
        waitCycles(17);
        applyStimulus(1, 0, 0, "pause_0005", 16'h0005, 1'b0, 1'b0, 1'b0);
        waitAndCheck(20, "paused_hold", 16'h0005, 1'b0, 1'b0, 1'b0);
        applyStimulus(1, 0, 0, "resume", 16'h0005, 1'b1, 1'b0, 1'b0);
        waitAndCheck(1, "resume_no_early", 16'h0005, 1'b1, 1'b0, 1'b0);
        waitAndCheck(1, "resume_tick", 16'h0006, 1'b1, 1'b0, 1'b0);
        waitAndCheck(16, "count_0010", 16'h0010, 1'b1, 1'b0, 1'b0);
        applyStimulus(0, 1, 0, "zero_in_run", 16'h0010, 1'b1, 1'b0, 1'b0);

        // Lap strobes
        waitAndCheck(107, "count_0037", 16'h0037, 1'b1, 1'b0, 1'b0);
        applyStimulus(0, 0, 1, "lap_0037", 16'h0037, 1'b1, 1'b1, 1'b0);
        waitAndCheck(1, "lap_single", 16'h0037, 1'b1, 1'b0, 1'b0);
        waitCycles(1);
        applyStimulus(0, 0, 1, "lap_with_tick", 16'h0038, 1'b1, 1'b1, 1'b0);
        applyStimulus(0, 0, 1, "lap_back_to_back", 16'h0038, 1'b1, 1'b1, 1'b0);
        waitAndCheck(1, "lap_end", 16'h0038, 1'b1, 1'b0, 1'b0);
        waitCycles(1);
        applyStimulus(1, 0, 1, "lap_pause_tick", 16'h0039, 1'b0, 1'b1, 1'b0);
        applyStimulus(0, 0, 1, "lap_paused", 16'h0039, 1'b0, 1'b0, 1'b0);
        applyStimulus(1, 1, 0, "zero_ss_pause", 16'h0039, 1'b1, 1'b0, 1'b0);
        waitAndCheck(3, "resume2_hold", 16'h0039, 1'b1, 1'b0, 1'b0);
        waitAndCheck(1, "resume2_tick", 16'h0040, 1'b1, 1'b0, 1'b0);
        applyStimulus(1, 0, 0, "pause_0040", 16'h0040, 1'b0, 1'b0, 1'b0);
        applyStimulus(0, 1, 0, "zero_pause", 16'h0000, 1'b0, 1'b0, 1'b0);
        applyStimulus(0, 1, 0, "zero_idle", 16'h0000, 1'b0, 1'b0, 1'b0);
        applyStimulus(0, 0, 1, "lap_idle", 16'h0000, 1'b0, 1'b0, 1'b0);

        // Asynchronous clear in the middle of a clock period while running
        applyStimulus(1, 0, 0, "start2", 16'h0000, 1'b1, 1'b0, 1'b0);
        waitAndCheck(10, "count_0002", 16'h0002, 1'b1, 1'b0, 1'b0);
        #2;
        clr = 1'b1;
        #1;
        pushExpect("clr_async", 16'h0000, 1'b0, 1'b0, 1'b0);
        checkOutput();
        @(negedge clk);
        clr = 1'b0;
        waitAndCheck(5, "idle_after_clr", 16'h0000, 1'b0, 1'b0, 1'b0);

        // Wrap from 59.99 and sticky overflow
        applyStimulus(1, 0, 0, "start3", 16'h0000, 1'b1, 1'b0, 1'b0);
        waitAndCheck(23999, "count_5999", 16'h5999, 1'b1, 1'b0, 1'b0);
        waitAndCheck(1, "wrap", 16'h0000, 1'b1, 1'b0, 1'b1);
        waitAndCheck(4, "after_wrap", 16'h0001, 1'b1, 1'b0, 1'b1);
        applyStimulus(1, 0, 0, "pause_ovf", 16'h0001, 1'b0, 1'b0, 1'b1);
        applyStimulus(0, 1, 0, "zero_clears_ovf", 16'h0000, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
